// File: rtl/dino_input_pkg.sv
// dino_input_pkg: shared types and default timing constants for the dino input conditioner
// Contents: jump FSM state type, board-rate defaults (100 MHz), reduced simulation values
package dino_input_pkg;
    typedef enum logic {IDLE, PENDING} jump_state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_JUMP_BUF_CYCLES = 10_000_000;
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_JUMP_BUF_CYCLES = 8;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-FF synchroniser, debounce counter and registered rise/fall pulses for one button
// Ports: i_clk clock, rst_n async active-low reset, i_btn raw button,
//        o_level debounced level, o_rise/o_fall one-cycle pulses on debounced edges
module debounce_channel
    import dino_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_CNT_W        = 20
) (
    input  logic i_clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [1:0]          r_sync;
    logic [DB_CNT_W-1:0] r_cnt;
    logic                r_stable;
    logic                r_rise;
    logic                r_fall;
    logic                w_diff;
    logic                w_done;

    assign w_diff = r_sync[1] != r_stable;
    // change accepted once the input has differed for DEBOUNCE_CYCLES consecutive cycles
    assign w_done = w_diff && (r_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_btn};
            r_cnt    <= (w_diff && !w_done) ? r_cnt + DB_CNT_W'(1) : '0;
            r_stable <= w_done ? r_sync[1] : r_stable;
            r_rise   <= w_done && r_sync[1];
            r_fall   <= w_done && !r_sync[1];
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/dino_input_conditioner.sv
// dino_input_conditioner: debounces jump/duck buttons and buffers jump presses until ack or timeout
// Ports: i_clk 100 MHz clock, rst_n async active-low reset, i_jump_btn/i_duck_btn raw buttons,
//        i_jump_ack consume pulse, o_jump_level/o_duck_level debounced levels,
//        o_jump_rise/o_duck_rise/o_duck_fall edge pulses, o_jump_req buffered request,
//        o_jump_expired pulse when a request times out
module dino_input_conditioner
    import dino_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DB_CNT_W        = 20,
    parameter int JUMP_BUF_CYCLES = DEF_JUMP_BUF_CYCLES,
    parameter int BUF_CNT_W       = 24
) (
    input  logic i_clk,
    input  logic rst_n,
    input  logic i_jump_btn,
    input  logic i_duck_btn,
    input  logic i_jump_ack,
    output logic o_jump_level,
    output logic o_duck_level,
    output logic o_jump_rise,
    output logic o_duck_rise,
    output logic o_duck_fall,
    output logic o_jump_req,
    output logic o_jump_expired
);
    jump_state_t          r_state;
    jump_state_t          w_next;
    logic [BUF_CNT_W-1:0] r_timer;
    logic [BUF_CNT_W-1:0] w_timer_next;
    logic                 r_expired;
    logic                 w_expire;
    logic                 w_valid_rise;
    logic                 w_jump_fall_unused;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_jump (
        .i_clk(i_clk), .rst_n(rst_n), .i_btn(i_jump_btn),
        .o_level(o_jump_level), .o_rise(o_jump_rise), .o_fall(w_jump_fall_unused)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_duck (
        .i_clk(i_clk), .rst_n(rst_n), .i_btn(i_duck_btn),
        .o_level(o_duck_level), .o_rise(o_duck_rise), .o_fall(o_duck_fall)
    );

    // a jump pressed while ducking is dropped
    assign w_valid_rise = o_jump_rise && !o_duck_level;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timer   <= w_timer_next;
            r_expired <= w_expire;
        end
    end

    // a fresh press always restarts the request, even alongside ack; ack beats timeout
    always_comb begin
        w_next       = r_state;
        w_timer_next = '0;
        w_expire     = 1'b0;
        if (w_valid_rise) begin
            w_next = PENDING;
        end else if (r_state == PENDING) begin
            if (i_jump_ack) begin
                w_next = IDLE;
            end else if (r_timer == BUF_CNT_W'(JUMP_BUF_CYCLES - 1)) begin
                w_next   = IDLE;
                w_expire = 1'b1;
            end else begin
                w_timer_next = r_timer + BUF_CNT_W'(1);
            end
        end
    end

    assign o_jump_req     = r_state == PENDING;
    assign o_jump_expired = r_expired;
endmodule

// File: doc/dino_input_conditioner.md
Name: dino_input_conditioner

Overview:
- Upstream stage between the board push-buttons and the jump/duck inputs of the game top level / game_management.
- Per button: 2-FF synchronisation, debounce, edge detection.
- Jump presses become a buffered request that is held until game logic acknowledges it or a timeout expires, so a press landing mid-frame is not lost.
- Runs on the 100 MHz board clock.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronised input must differ from the stable state before the change is accepted (10 ms).
- DB_CNT_W, 20, debounce counter width; must satisfy 2^DB_CNT_W >= DEBOUNCE_CYCLES.
- JUMP_BUF_CYCLES, 10_000_000, cycles a pending jump request survives without ack (100 ms).
- BUF_CNT_W, 24, jump buffer timer width; must satisfy 2^BUF_CNT_W >= JUMP_BUF_CYCLES.

Ports:
- i_clk  in  1  board clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- i_jump_btn  in  1  raw jump button, asynchronous, bouncy
- i_duck_btn  in  1  raw duck button, asynchronous, bouncy
- i_jump_ack  in  1  game logic has consumed the pending jump (single-cycle pulse)
- o_jump_level  out  1  debounced jump button level
- o_duck_level  out  1  debounced duck button level
- o_jump_rise  out  1  one-cycle pulse on debounced jump 0->1
- o_duck_rise  out  1  one-cycle pulse on debounced duck 0->1
- o_duck_fall  out  1  one-cycle pulse on debounced duck 1->0
- o_jump_req  out  1  buffered jump request, level
- o_jump_expired  out  1  one-cycle pulse when a pending request times out

Behaviour:
- Reset (async, rst_n=0):
  - All synchroniser flops, stable states, counters and FSM cleared.
  - Every output is 0. FSM is IDLE.
  - Reset release takes effect on the next i_clk rising edge.
- Synchroniser: 2 flops per button, reset value 0.
- Debounce, per channel:
  - sync == stable: counter holds 0.
  - sync != stable: counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync, counter <= 0.
  - Any cycle where sync returns to stable clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: a clean input change at edge N appears on o_*_level at edge N+2+DEBOUNCE_CYCLES.
- Edge pulses:
  - Registered and coincident with the first cycle of the new level.
  - Width exactly 1 cycle. Never asserted while in reset.
- Jump FSM states: IDLE, PENDING.
  - IDLE: o_jump_req=0. On o_jump_rise with o_duck_level=0, go to PENDING with timer 0. A rise while ducking is discarded.
  - PENDING: o_jump_req=1.
    - i_jump_ack=1: go to IDLE.
    - Else timer == JUMP_BUF_CYCLES-1: go to IDLE, o_jump_expired=1 for one cycle.
    - Else timer increments.
  - PENDING with a new valid jump rise and no ack: stay PENDING, timer restarts at 0.
  - Simultaneous ack and valid rise: stay PENDING, timer 0. The new press is a fresh request.
  - Simultaneous ack and timeout: ack wins, no expired pulse.
  - Ack in IDLE: ignored.
- o_jump_req rises the cycle after o_jump_rise. It falls the cycle after ack or timeout.
- Duck has no buffering; the level passes straight through after debounce.
- Counters saturate by construction; no wrap-around is reachable.

Decomposition:
- Shared package dino_input_pkg:
  - jump FSM state typedef (IDLE, PENDING)
  - default DEBOUNCE_CYCLES / JUMP_BUF_CYCLES constants
  - reduced simulation values
- Sub-module debounce_channel:
  - contents: synchroniser + debounce counter + rise/fall pulse generation
  - parameterised by DEBOUNCE_CYCLES and DB_CNT_W
  - instantiated once per button
- The top of this block holds the two instances plus the jump FSM and buffer timer.

Test Plan (DEBOUNCE_CYCLES=4, JUMP_BUF_CYCLES=8):
- Reset: assert rst_n=0 mid-PENDING with both buttons held -> all outputs 0 immediately, without waiting for a clock; after release with buttons still held, levels return at edge 2+4.
- Bounce: toggle i_jump_btn every 2 cycles for 20 cycles, then hold 1 -> o_jump_level stays 0 during the toggling and rises exactly 6 edges after the final stable transition; exactly one o_jump_rise.
- Glitch: i_duck_btn high for 3 cycles -> o_duck_level, o_duck_rise, o_duck_fall all remain 0.
- Ack: clean jump press, i_jump_ack pulsed 3 cycles after o_jump_req rises -> o_jump_req high for exactly 3 cycles, no o_jump_expired.
- Timeout: clean jump press, no ack -> o_jump_req high for 8 cycles, o_jump_expired pulses once as the request drops.
- Duck blocks jump: duck held and debounced, then jump pressed -> o_jump_rise pulses, o_jump_req stays 0. Same-cycle ack plus new rise in PENDING -> o_jump_req stays 1 and the timer restarts (drops 8 cycles later).
